// File: rtl/vga_fb_dbuf.sv
// Double-buffered palette-code frame buffer: PPU writes the back bank, VGA scans
// the front bank through a 2-stage decode pipeline; banks flip only at vblank.
module vga_fb_dbuf #(
  parameter int H_RES  = 256,
  parameter int V_RES  = 240,
  parameter int CODE_W = 6,
  parameter int CH_W   = 3,
  localparam int XW    = $clog2(H_RES),
  localparam int YW    = $clog2(V_RES),
  localparam int DEPTH = H_RES * V_RES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ppu_we,
  input  logic [XW-1:0]     ppu_ptr_x,
  input  logic [YW-1:0]     ppu_ptr_y,
  input  logic [CODE_W-1:0] ppu_DI,
  output logic              ppu_ready,
  output logic              ppu_wr_drop,
  input  logic              frame_done,
  input  logic              clear_en,
  input  logic [CODE_W-1:0] clear_code,
  input  logic              vga_re,
  input  logic [XW-1:0]     pix_ptr_x,
  input  logic [YW-1:0]     pix_ptr_y,
  input  logic              vblank_start,
  output logic [3*CH_W-1:0] rgb,
  output logic              rgb_valid,
  output logic              front_sel,
  output logic              swap_pend,
  output logic              clearing,
  output logic              frame_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XW:0] X_LIM = (XW+1)'(H_RES);
  localparam logic [YW:0] Y_LIM = (YW+1)'(V_RES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWAP_PEND,
    S_CLEAR
  } state_t;

  state_t r_state, w_state_nx;

  logic [CODE_W-1:0] r_mem0 [0:DEPTH-1];
  logic [CODE_W-1:0] r_mem1 [0:DEPTH-1];

  logic              r_front;
  logic [AW-1:0]     r_clr_cnt;
  logic [CODE_W-1:0] r_clr_code;
  logic              r_wr_drop;
  logic              r_overrun;

  logic [CODE_W-1:0] r_code;
  logic              r_v1;
  logic              r_oor1;
  logic [3*CH_W-1:0] r_rgb;
  logic              r_rgb_valid;

  logic              w_swap;
  logic              w_overrun;
  logic              w_clr_done;
  logic              w_ppu_in;
  logic              w_pix_in;
  logic              w_ppu_ok;
  logic              w_clr_we;
  logic              w_we;
  logic              w_wbank;
  logic [AW-1:0]     w_waddr;
  logic [CODE_W-1:0] w_wdata;
  logic [AW-1:0]     w_raddr;
  logic [CODE_W+5:0] w_code_ext;
  logic [8:0]        w_pal;
  logic [3*CH_W-1:0] w_rgb_dec;

  function automatic logic [AW-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(H_RES) + AW'(x);
  endfunction

  // 3-bit channel values packed as octal {R,G,B}; columns D/E/F are black.
  function automatic logic [8:0] pal9(input logic [5:0] c);
    logic [8:0] p;
    case (c)
      6'h00: p = 9'o333; 6'h01: p = 9'o114; 6'h02: p = 9'o015; 6'h03: p = 9'o215;
      6'h04: p = 9'o413; 6'h05: p = 9'o512; 6'h06: p = 9'o510; 6'h07: p = 9'o310;
      6'h08: p = 9'o220; 6'h09: p = 9'o030; 6'h0A: p = 9'o030; 6'h0B: p = 9'o031;
      6'h0C: p = 9'o023;
      6'h10: p = 9'o555; 6'h11: p = 9'o036; 6'h12: p = 9'o237; 6'h13: p = 9'o427;
      6'h14: p = 9'o616; 6'h15: p = 9'o714; 6'h16: p = 9'o610; 6'h17: p = 9'o520;
      6'h18: p = 9'o430; 6'h19: p = 9'o150; 6'h1A: p = 9'o050; 6'h1B: p = 9'o052;
      6'h1C: p = 9'o045;
      6'h20: p = 9'o777; 6'h21: p = 9'o357; 6'h22: p = 9'o467; 6'h23: p = 9'o647;
      6'h24: p = 9'o737; 6'h25: p = 9'o735; 6'h26: p = 9'o742; 6'h27: p = 9'o752;
      6'h28: p = 9'o661; 6'h29: p = 9'o371; 6'h2A: p = 9'o373; 6'h2B: p = 9'o375;
      6'h2C: p = 9'o066;
      6'h30: p = 9'o777; 6'h31: p = 9'o577; 6'h32: p = 9'o667; 6'h33: p = 9'o667;
      6'h34: p = 9'o767; 6'h35: p = 9'o766; 6'h36: p = 9'o765; 6'h37: p = 9'o775;
      6'h38: p = 9'o774; 6'h39: p = 9'o674; 6'h3A: p = 9'o575; 6'h3B: p = 9'o577;
      6'h3C: p = 9'o577;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Left-align the 3-bit value and repeat its bits down to fill CH_W.
  function automatic logic [CH_W-1:0] expand(input logic [2:0] v);
    logic [3*CH_W-1:0] rep;
    rep = {CH_W{v}};
    return rep[3*CH_W-1 -: CH_W];
  endfunction

  assign w_ppu_in = ({1'b0, ppu_ptr_x} < X_LIM) && ({1'b0, ppu_ptr_y} < Y_LIM);
  assign w_pix_in = ({1'b0, pix_ptr_x} < X_LIM) && ({1'b0, pix_ptr_y} < Y_LIM);

  assign w_ppu_ok = ppu_we && (r_state == S_IDLE) && w_ppu_in;
  assign w_clr_we = (r_state == S_CLEAR);
  assign w_we     = reset_n && (w_ppu_ok || w_clr_we);
  assign w_wbank  = ~r_front;
  assign w_waddr  = w_clr_we ? r_clr_cnt  : lin_addr(ppu_ptr_x, ppu_ptr_y);
  assign w_wdata  = w_clr_we ? r_clr_code : ppu_DI;
  assign w_raddr  = w_pix_in ? lin_addr(pix_ptr_x, pix_ptr_y) : '0;

  always_comb begin
    w_state_nx = r_state;
    w_swap     = 1'b0;
    w_overrun  = 1'b0;
    w_clr_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_done) w_state_nx = S_SWAP_PEND;
      end
      S_SWAP_PEND: begin
        w_overrun = frame_done;
        if (vblank_start) begin
          w_swap     = 1'b1;
          w_state_nx = clear_en ? S_CLEAR : S_IDLE;
        end
      end
      S_CLEAR: begin
        w_overrun = frame_done;
        if (r_clr_cnt == LAST_ADDR) begin
          w_clr_done = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !w_wbank) r_mem0[w_waddr] <= w_wdata;
    if (w_we &&  w_wbank) r_mem1[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_front    <= 1'b0;
      r_clr_cnt  <= '0;
      r_clr_code <= '0;
      r_wr_drop  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wr_drop <= ppu_we && !((r_state == S_IDLE) && w_ppu_in);
      r_overrun <= w_overrun;
      if (w_swap) begin
        r_front    <= ~r_front;
        r_clr_code <= clear_code;
      end
      if (r_state == S_CLEAR) r_clr_cnt <= w_clr_done ? '0 : r_clr_cnt + 1'b1;
    end
  end

  assign w_code_ext = {6'b0, r_code};
  assign w_pal      = (|w_code_ext[CODE_W+5:6]) ? '0 : pal9(w_code_ext[5:0]);
  assign w_rgb_dec  = {expand(w_pal[8:6]), expand(w_pal[5:3]), expand(w_pal[2:0])};

  // Bank is chosen from r_front at issue time, so a swap on the next edge cannot alter it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_code      <= '0;
      r_v1        <= 1'b0;
      r_oor1      <= 1'b0;
      r_rgb       <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_v1        <= vga_re;
      r_oor1      <= vga_re && !w_pix_in;
      if (vga_re) r_code <= r_front ? r_mem1[w_raddr] : r_mem0[w_raddr];
      r_rgb_valid <= r_v1;
      if (r_v1) r_rgb <= r_oor1 ? '0 : w_rgb_dec;
    end
  end

  assign ppu_ready     = (r_state == S_IDLE);
  assign swap_pend     = (r_state == S_SWAP_PEND);
  assign clearing      = (r_state == S_CLEAR);
  assign ppu_wr_drop   = r_wr_drop;
  assign frame_overrun = r_overrun;
  assign front_sel     = r_front;
  assign rgb           = r_rgb;
  assign rgb_valid     = r_rgb_valid;

endmodule

// File: tb/tb_vga_fb_dbuf.sv
// Directed bench: default build (u0) for decode, swap and clear; small CH_W=8
// build (u1, H_RES=200, V_RES=4) for range drops, channel expansion and mid-clear reset.
module tb_vga_fb_dbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: default parameters
  logic       reset_n, ppu_we, frame_done, clear_en, vga_re, vblank;
  logic [7:0] ppu_x, pix_x;
  logic [7:0] ppu_y, pix_y;
  logic [5:0] ppu_di, clear_code;
  logic       ppu_ready, wr_drop, rgb_valid, front_sel, swap_pend, clearing, overrun;
  logic [8:0] rgb;

  vga_fb_dbuf u0 (
    .clk(clk), .reset_n(reset_n), .ppu_we(ppu_we), .ppu_ptr_x(ppu_x), .ppu_ptr_y(ppu_y),
    .ppu_DI(ppu_di), .ppu_ready(ppu_ready), .ppu_wr_drop(wr_drop), .frame_done(frame_done),
    .clear_en(clear_en), .clear_code(clear_code), .vga_re(vga_re), .pix_ptr_x(pix_x),
    .pix_ptr_y(pix_y), .vblank_start(vblank), .rgb(rgb), .rgb_valid(rgb_valid),
    .front_sel(front_sel), .swap_pend(swap_pend), .clearing(clearing),
    .frame_overrun(overrun)
  );

  // u1: narrow frame, 8-bit channels
  logic        b_reset_n, b_we, b_fd, b_ce, b_re, b_vb;
  logic [7:0]  b_x, b_px;
  logic [1:0]  b_y, b_py;
  logic [5:0]  b_di, b_cc;
  logic        b_ready, b_drop, b_valid, b_front, b_swap_pend, b_clearing, b_overrun;
  logic [23:0] b_rgb;

  vga_fb_dbuf #(.H_RES(200), .V_RES(4), .CODE_W(6), .CH_W(8)) u1 (
    .clk(clk), .reset_n(b_reset_n), .ppu_we(b_we), .ppu_ptr_x(b_x), .ppu_ptr_y(b_y),
    .ppu_DI(b_di), .ppu_ready(b_ready), .ppu_wr_drop(b_drop), .frame_done(b_fd),
    .clear_en(b_ce), .clear_code(b_cc), .vga_re(b_re), .pix_ptr_x(b_px),
    .pix_ptr_y(b_py), .vblank_start(b_vb), .rgb(b_rgb), .rgb_valid(b_valid),
    .front_sel(b_front), .swap_pend(b_swap_pend), .clearing(b_clearing),
    .frame_overrun(b_overrun)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] code;
    logic [8:0] exp;
  } rec_t;

  rec_t tbl [8];

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
    ppu_we = 1'b1; ppu_x = x; ppu_y = y; ppu_di = c;
    tick();
    ppu_we = 1'b0;
  endtask

  task automatic swap0();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_pend_set", 24'(swap_pend), 1);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("swap_pend_clr", 24'(swap_pend), 0);
  endtask

  task automatic rd0(input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp,
                     input string nm);
    vga_re = 1'b1; pix_x = x; pix_y = y;
    tick();
    vga_re = 1'b0;
    tick();
    chk({nm, "_rgb"}, 24'(rgb), 24'(exp));
    chk({nm, "_valid"}, 24'(rgb_valid), 1);
  endtask

  task automatic wr1(input logic [7:0] x, input logic [1:0] y, input logic [5:0] c);
    b_we = 1'b1; b_x = x; b_y = y; b_di = c;
    tick();
    b_we = 1'b0;
  endtask

  task automatic rd1(input logic [7:0] x, input logic [1:0] y, input logic [23:0] exp,
                     input string nm);
    b_re = 1'b1; b_px = x; b_py = y;
    tick();
    b_re = 1'b0;
    tick();
    chk({nm, "_rgb"}, b_rgb, exp);
    chk({nm, "_valid"}, 24'(b_valid), 1);
  endtask

  initial begin
    int n;
    tbl[0] = '{x: 8'd10,  y: 8'd20,  code: 6'h16, exp: 9'b110_001_000};
    tbl[1] = '{x: 8'd0,   y: 8'd0,   code: 6'h00, exp: 9'b011_011_011};
    tbl[2] = '{x: 8'd1,   y: 8'd0,   code: 6'h01, exp: 9'b001_001_100};
    tbl[3] = '{x: 8'd255, y: 8'd239, code: 6'h2C, exp: 9'b000_110_110};
    tbl[4] = '{x: 8'd100, y: 8'd5,   code: 6'h30, exp: 9'h1FF};
    tbl[5] = '{x: 8'd7,   y: 8'd7,   code: 6'h0D, exp: 9'h000};
    tbl[6] = '{x: 8'd8,   y: 8'd8,   code: 6'h3F, exp: 9'h000};
    tbl[7] = '{x: 8'd9,   y: 8'd9,   code: 6'h20, exp: 9'h1FF};

    reset_n = 1'b0; ppu_we = 1'b0; frame_done = 1'b0; clear_en = 1'b0; vga_re = 1'b0;
    vblank = 1'b0; ppu_x = '0; ppu_y = '0; pix_x = '0; pix_y = '0; ppu_di = '0;
    clear_code = '0;
    b_reset_n = 1'b0; b_we = 1'b0; b_fd = 1'b0; b_ce = 1'b0; b_re = 1'b0; b_vb = 1'b0;
    b_x = '0; b_y = '0; b_px = '0; b_py = '0; b_di = '0; b_cc = '0;

    tick();
    tick();
    chk("rst_ready", 24'(ppu_ready), 1);
    chk("rst_front", 24'(front_sel), 0);
    chk("rst_swap_pend", 24'(swap_pend), 0);
    chk("rst_clearing", 24'(clearing), 0);
    chk("rst_rgb", 24'(rgb), 0);
    chk("rst_rgb_valid", 24'(rgb_valid), 0);
    chk("rst_wr_drop", 24'(wr_drop), 0);
    chk("rst_overrun", 24'(overrun), 0);
    reset_n = 1'b1;
    tick();

    // Preload bank0 with 0x20 at (10,20) then make bank0 the front
    swap0();
    chk("front_swap1", 24'(front_sel), 1);
    wr0(8'd10, 8'd20, 6'h20);
    swap0();
    chk("front_swap2", 24'(front_sel), 0);

    foreach (tbl[i]) wr0(tbl[i].x, tbl[i].y, tbl[i].code);
    rd0(8'd10, 8'd20, 9'h1FF, "no_tear");

    swap0();
    chk("front_swap3", 24'(front_sel), 1);
    foreach (tbl[i]) rd0(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("tbl%0d", i));

    tick();
    chk("hold_valid", 24'(rgb_valid), 0);
    chk("hold_rgb", 24'(rgb), 24'h1FF);

    rd0(8'd5, 8'd240, 9'h000, "oor_read");

    ppu_we = 1'b1; ppu_x = 8'd3; ppu_y = 8'd240; ppu_di = 6'h20;
    tick();
    ppu_we = 1'b0;
    chk("oor_wr_drop", 24'(wr_drop), 1);
    tick();
    chk("oor_wr_drop_end", 24'(wr_drop), 0);
    wr0(8'd20, 8'd1, 6'h11);
    chk("ok_wr_no_drop", 24'(wr_drop), 0);

    // frame_done and vblank together: swap must wait for the next vblank
    frame_done = 1'b1; vblank = 1'b1;
    tick();
    frame_done = 1'b0; vblank = 1'b0;
    chk("coinc_swap_pend", 24'(swap_pend), 1);
    chk("coinc_front", 24'(front_sel), 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("overrun_pulse", 24'(overrun), 1);
    chk("overrun_still_pend", 24'(swap_pend), 1);
    tick();
    chk("overrun_end", 24'(overrun), 0);

    clear_en = 1'b1; clear_code = 6'h0F; vblank = 1'b1;
    tick();
    vblank = 1'b0; clear_en = 1'b0;
    chk("clr_front", 24'(front_sel), 0);
    chk("clr_active", 24'(clearing), 1);
    chk("clr_not_ready", 24'(ppu_ready), 0);
    n = 0;
    while (clearing && n < 70000) begin
      if (n == 100) begin
        ppu_we = 1'b1; ppu_x = 8'd0; ppu_y = 8'd0; ppu_di = 6'h20;
      end
      if (n == 101) begin
        ppu_we = 1'b0;
        chk("clr_wr_drop", 24'(wr_drop), 1);
      end
      n++;
      tick();
    end
    chk("clr_cycles", 24'(n), 24'd61440);
    chk("clr_done_ready", 24'(ppu_ready), 1);

    swap0();
    chk("front_swap4", 24'(front_sel), 1);
    rd0(8'd0, 8'd0, 9'h000, "cleared_0_0");
    rd0(8'd10, 8'd20, 9'h000, "cleared_10_20");
    rd0(8'd255, 8'd239, 9'h000, "cleared_last");

    // u1: H_RES=200, V_RES=4, CH_W=8
    b_reset_n = 1'b1;
    tick();
    b_we = 1'b1; b_x = 8'd255; b_y = 2'd0; b_di = 6'h30;
    tick();
    b_we = 1'b0;
    chk("u1_oor_wr_drop", 24'(b_drop), 1);
    wr1(8'd3, 2'd1, 6'h30);
    chk("u1_wr_no_drop", 24'(b_drop), 0);
    wr1(8'd4, 2'd1, 6'h01);
    b_fd = 1'b1;
    tick();
    b_fd = 1'b0; b_vb = 1'b1;
    tick();
    b_vb = 1'b0;
    chk("u1_front", 24'(b_front), 1);
    rd1(8'd200, 2'd0, 24'h000000, "u1_oor_read");
    rd1(8'd3, 2'd1, 24'hFFFFFF, "u1_code30");
    rd1(8'd4, 2'd1, 24'h242492, "u1_code01");

    b_ce = 1'b1; b_cc = 6'h0F; b_fd = 1'b1;
    tick();
    b_fd = 1'b0; b_vb = 1'b1;
    tick();
    b_vb = 1'b0; b_ce = 1'b0;
    chk("u1_clearing", 24'(b_clearing), 1);
    repeat (50) tick();
    b_reset_n = 1'b0;
    tick();
    chk("u1_rst_clearing", 24'(b_clearing), 0);
    chk("u1_rst_front", 24'(b_front), 0);
    chk("u1_rst_ready", 24'(b_ready), 1);
    chk("u1_rst_swap_pend", 24'(b_swap_pend), 0);
    chk("u1_rst_rgb", b_rgb, 24'h000000);
    chk("u1_rst_valid", 24'(b_valid), 0);
    chk("u1_rst_drop", 24'(b_drop), 0);
    chk("u1_rst_overrun", 24'(b_overrun), 0);
    b_reset_n = 1'b1;
    tick();
    chk("u1_idle_after_rst", 24'(b_clearing), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
